// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default operand width and the final-iteration index.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int LAST_ITER = DEF_WIDTH - 1;

  function automatic int last_iter(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/mult_seq_shift_add_if.sv
// Start/busy/done handshake and operand/product bus between the ALU
// controller (master) and the multiplier (slave).
interface mult_seq_shift_add_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input  busy, done, product);
  modport slave  (input  start, a, b, output busy, done, product);
endinterface

// File: rtl/mult_add_stage.sv
// Combinational WIDTH-bit adder with carry out; the single add pass used per
// multiplier iteration.
module mult_add_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum    = w_full[WIDTH-1:0];
  assign cout   = w_full[WIDTH];
endmodule

// File: rtl/mult_seq_shift_add.sv
// Radix-2 shift-add unsigned multiplier, one adder pass per clock.
// Optional macro MULT_EARLY_TERM_EN: a zero operand skips RUN and finishes at once.
module mult_seq_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_seq_shift_add_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(last_iter(WIDTH));

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_zero;
  logic                 w_last;
  logic [WIDTH-1:0]     w_add;
  logic                 w_cout;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_cat;
  logic [2*WIDTH-1:0]   w_shift;

  mult_add_stage #(.WIDTH(WIDTH)) u_add (
    .a    (r_acc_hi),
    .b    (r_mcand),
    .cin  (1'b0),
    .sum  (w_add),
    .cout (w_cout)
  );

  // Carry out lands in bit WIDTH of w_sum and shifts down into acc_hi's MSB.
  assign w_sum   = r_acc_lo[0] ? {w_cout, w_add} : {1'b0, r_acc_hi};
  assign w_cat   = {w_sum, r_acc_lo};
  assign w_shift = w_cat[2*WIDTH:1];

  assign w_accept = bus.start & (r_state != RUN);
  assign w_last   = (r_cnt == LAST_CNT);
`ifdef MULT_EARLY_TERM_EN
  assign w_zero   = (bus.a == '0) | (bus.b == '0);
`else
  assign w_zero   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) w_next = w_zero ? DONE : RUN;
        else           w_next = IDLE;
      end
      RUN:     if (w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand  <= bus.a;
      r_acc_hi <= '0;
      r_acc_lo <= bus.b;
      r_cnt    <= '0;
      if (w_zero) r_product <= '0;
    end else if (r_state == RUN) begin
      r_acc_hi <= w_shift[2*WIDTH-1:WIDTH];
      r_acc_lo <= w_shift[WIDTH-1:0];
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_product <= w_shift;
    end
  end

  // done and busy decode straight from the state register, so both are registered.
  assign bus.busy    = (r_state == RUN);
  assign bus.done    = (r_state == DONE);
  assign bus.product = r_product;

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Directed and randomized bench for the shift-add multiplier against a*b.
module tb_mult_seq_shift_add;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_seq_shift_add_if #(.WIDTH(W)) bus ();

  mult_seq_shift_add #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] prev   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
    if (a == 0 || b == 0) return 0;
`endif
    return W;
  endfunction

  // Drive a start now, let the next rising edge accept it, then scramble operands.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Called just after the accepting edge; returns sampled inside the done cycle.
  task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int restart_at, input string tag);
    int          n      = 1;
    int          busy_n = 0;
    logic        held   = 1'b1;
    logic [63:0] exp    = 64'(a) * 64'(b);
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.product !== prev) held = 1'b0;
      if (n == restart_at) begin
        bus.start = 1'b1;
        bus.a     = 1;
        bus.b     = 1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    chk({tag, " latency"}, 64'(n - 1), 64'(exp_lat(a, b)));
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_lat(a, b)));
    chk({tag, " product_held"}, 64'(held), 64'd1);
    chk({tag, " product"}, bus.product, exp);
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    prev = exp;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int restart_at, input string tag);
    @(negedge clk);
    issue(a, b);
    wait_done(a, b, restart_at, tag);
    @(posedge clk); #1;
    chk({tag, " done_pulse_end"}, 64'(bus.done), 64'd0);
    chk({tag, " product_after"}, bus.product, prev);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset product", bus.product, 64'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    do_op(32'd3, 32'd5, 0, "t1");
    chk("t1 const", bus.product, 64'h0000_0000_0000_000F);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "t2");
    chk("t2 const", bus.product, 64'hFFFF_FFFE_0000_0001);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 10, "t3");

    // Back-to-back: second start issued inside the first op's done cycle.
    @(negedge clk);
    issue(32'd7, 32'd6);
    wait_done(32'd7, 32'd6, 0, "t4a");
    issue(32'd2, 32'd9);
    wait_done(32'd2, 32'd9, 0, "t4b");
    @(posedge clk); #1;
    chk("t4 done_pulse_end", 64'(bus.done), 64'd0);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    issue(32'd100, 32'd200);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 busy_on_reset", 64'(bus.busy), 64'd0);
    chk("t5 done_on_reset", 64'(bus.done), 64'd0);
    chk("t5 product_on_reset", bus.product, 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("t5 done_in_reset", 64'(bus.done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    prev = '0;
    do_op(32'd100, 32'd200, 0, "t5");

    do_op(32'h0, 32'hDEAD_BEEF, 0, "t6");
    do_op(32'h1234, 32'h0, 0, "t6b");

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra = '0;
      if ($urandom_range(0, 4) == 0) rb = '0;
      do_op(ra, rb, (i % 3 == 0) ? int'($urandom_range(1, 30)) : 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
